// File: rtl/bram_dump_reader.sv
// Debug read-side master: walks a range of 32-bit RAM words and streams each
// word big-endian, one byte at a time, through the UART start/done handshake.
module bram_dump_reader #(
  parameter int ADDRESS_BITS = 8,
  parameter int DATA_BITS    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [ADDRESS_BITS-1:0] i_base_address,
  input  logic [ADDRESS_BITS:0]   i_count,
  output logic [ADDRESS_BITS-1:0] o_mem_address,
  input  logic [DATA_BITS-1:0]    i_mem_data,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int BYTES = DATA_BITS / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE   = IDX_W'(1);
  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE  = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS:0]   WORDS_ONE = (ADDRESS_BITS + 1)'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state;
  logic [DATA_BITS-1:0]  shift_reg;
  logic [IDX_W-1:0]      byte_idx;
  logic [ADDRESS_BITS:0] words_left;

  // A zero count selects the whole address space.
  function automatic logic [ADDRESS_BITS:0] word_total(input logic [ADDRESS_BITS:0] cnt);
    if (cnt == '0)
      return {1'b1, {ADDRESS_BITS{1'b0}}};
    else
      return cnt;
  endfunction

  // The unsent byte always sits at the top of the shift register.
  assign o_tx_data = shift_reg[DATA_BITS-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift_reg     <= '0;
      byte_idx      <= '0;
      words_left    <= '0;
      o_mem_address <= '0;
      o_tx_start    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_mem_address <= i_base_address;
            words_left    <= word_total(i_count);
            byte_idx      <= '0;
            o_busy        <= 1'b1;
            state         <= FETCH;
          end
        end
        // The RAM registers the word on the negedge inside this cycle.
        FETCH: state <= LOAD;
        LOAD: begin
          shift_reg  <= i_mem_data;
          byte_idx   <= '0;
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        // i_tx_done seen here belongs to no byte of ours and is dropped.
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_idx != LAST_IDX) begin
              shift_reg  <= shift_reg << 8;
              byte_idx   <= byte_idx + IDX_ONE;
              o_tx_start <= 1'b1;
              state      <= SEND;
            end else if (words_left > WORDS_ONE) begin
              o_mem_address <= o_mem_address + ADDR_ONE;
              words_left    <= words_left - WORDS_ONE;
              state         <= FETCH;
            end else begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_dump_reader.sv
// Scoreboard bench for bram_dump_reader with a negedge RAM model and a
// transmitter model answering each start pulse after a programmable delay.
module tb_bram_dump_reader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        spur_start;
  logic [7:0]  i_base_address;
  logic [8:0]  i_count;
  logic [7:0]  o_mem_address;
  logic [31:0] i_mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        rsp_done;
  logic        spur_fetch_done;
  logic        spur_send_done;
  logic        o_busy;
  logic        o_done;
  logic        tx_done;

  logic [31:0] mem [256];

  typedef struct {
    logic [7:0] b;
    logic [7:0] a;
  } exp_t;
  exp_t exp_q[$];
  int   start_times[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int last_done = -100;
  int tx_delay = 5;
  bit spur_en = 0;
  bit busy_next = 0;

  assign tx_done = rsp_done | spur_fetch_done | spur_send_done;

  bram_dump_reader dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start | spur_start),
    .i_base_address (i_base_address),
    .i_count        (i_count),
    .o_mem_address  (o_mem_address),
    .i_mem_data     (i_mem_data),
    .o_tx_data      (o_tx_data),
    .o_tx_start     (o_tx_start),
    .i_tx_done      (tx_done),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM: registers the addressed word on the negedge.
  initial begin
    i_mem_data = '0;
    forever begin
      @(negedge clk);
      i_mem_data = mem[o_mem_address];
    end
  end

  // Transmitter: done pulse tx_delay cycles after each start pulse.
  initial begin
    rsp_done = 0;
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        repeat (tx_delay) @(posedge clk);
        #1 rsp_done = 1;
        @(posedge clk);
        #1 rsp_done = 0;
      end
    end
  end

  // Noise: spurious done in the SEND cycle, spurious start during WAIT_TX.
  initial begin
    spur_send_done = 0;
    spur_start = 0;
    forever begin
      @(negedge clk);
      if (spur_en && o_tx_start) begin
        spur_send_done = 1;
        @(posedge clk);
        #1 spur_send_done = 0;
        spur_start = 1;
        @(posedge clk);
        #1 spur_start = 0;
      end
    end
  end

  // Output monitor and scoreboard consumer.
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        tx_cnt++;
        start_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(o_tx_data), 32'hxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tx_byte", 32'(o_tx_data), 32'(e.b));
          chk("mem_addr", 32'(o_mem_address), 32'(e.a));
        end
      end
      if (tx_done) last_done = cyc;
      if (o_done) begin
        done_cnt++;
        chk("done_latency", 32'(cyc), 32'(last_done + 1));
        chk("busy_in_done", 32'(o_busy), 32'd1);
        busy_next = 1;
      end else if (busy_next) begin
        chk("busy_fall", 32'(o_busy), 32'd0);
        busy_next = 0;
      end
    end
  end

  task automatic push_words(input logic [7:0] base, input int n);
    for (int w = 0; w < n; w++) begin
      logic [7:0] a;
      logic [31:0] d;
      a = base + 8'(w);
      d = mem[a];
      for (int b = 0; b < 4; b++) begin
        exp_t e;
        e.b = d[31 - 8*b -: 8];
        e.a = a;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_dump(input logic [7:0] base, input logic [8:0] cnt,
                          input int delay, input bit spur);
    int c, d0, t0, n, words;
    words = (cnt == 0) ? 256 : int'(cnt);
    tx_delay = delay;
    start_times.delete();
    d0 = done_cnt;
    t0 = tx_cnt;
    push_words(base, words);
    @(posedge clk);
    #1 i_start = 1; i_base_address = base; i_count = cnt;
    c = cyc;
    @(negedge clk);
    chk("busy_before", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1 i_start = spur; spur_fetch_done = spur;
    if (spur) begin i_base_address = 8'h20; i_count = 9'd3; end
    @(negedge clk);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    @(posedge clk);
    #1 spur_fetch_done = 0;
    spur_en = spur;
    @(posedge clk);
    #1 i_start = 0;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("done_timeout", 32'd0, 32'd1);
    spur_en = 0;
    repeat (8) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("byte_count", 32'(tx_cnt - t0), 32'(words * 4));
    if (start_times.size() > 0)
      chk("start_latency", 32'(start_times[0] - c), 32'd3);
    exp_q.delete();
  endtask

  initial begin
    int seen, d0, n;
    rst = 1; i_start = 0; i_base_address = 0; i_count = 0; spur_fetch_done = 0;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    // start together with reset must be ignored
    #1 i_start = 1; i_base_address = 8'h10; i_count = 9'd1;
    @(posedge clk);
    #1 rst = 0; i_start = 0;
    @(negedge clk);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_addr", 32'(o_mem_address), 32'd0);
    @(negedge clk);
    chk("rst_wins_busy", 32'(o_busy), 32'd0);

    // single word, slow transmitter
    run_dump(8'h10, 9'd1, 5, 0);

    // same dump under repeated starts and stray done pulses
    run_dump(8'h10, 9'd1, 5, 1);

    // reset while waiting on the second byte of word 0
    tx_delay = 5;
    push_words(8'h10, 1);
    d0 = done_cnt;
    @(posedge clk);
    #1 i_start = 1; i_base_address = 8'h10; i_count = 9'd1;
    @(posedge clk);
    #1 i_start = 0;
    seen = 0; n = 0;
    while (seen < 2 && n < 200) begin
      @(negedge clk);
      if (o_tx_start) seen++;
      n++;
    end
    if (n >= 200) chk("second_byte_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_tx_data", 32'(o_tx_data), 32'd0);
    chk("midrst_tx_start", 32'(o_tx_start), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_addr", 32'(o_mem_address), 32'd0);
    exp_q.delete();
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_dump(8'h10, 9'd1, 5, 0);

    // address wrap, slow then immediate transmitter
    mem[8'hFF] = 32'h11223344;
    mem[8'h00] = 32'h55667788;
    run_dump(8'hFF, 9'd2, 5, 0);
    run_dump(8'hFF, 9'd2, 1, 0);
    chk("n_starts", 32'(start_times.size()), 32'd8);
    if (start_times.size() == 8) begin
      for (int i = 1; i < 8; i++)
        chk("start_spacing", 32'(start_times[i] - start_times[i-1]), (i == 4) ? 32'd4 : 32'd2);
    end

    // full-memory dump from mid-range base
    for (int a = 0; a < 256; a++) mem[a] = {4{8'(a)}};
    run_dump(8'h80, 9'd0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_dump_reader.md
Name: bram_dump_reader

Overview:
- Read-side master for the datapath's 32-bit block RAM. On a start command it walks a range of word addresses and fetches each word.
- Each word is split into bytes and streamed to the UART transmitter through a start/done handshake.
- It is used by the debug unit to dump data/instruction memory to the host after a program halts.
- It never writes memory. The integrator holds the RAM write enable low while o_busy=1.

Parameters:
- ADDRESS_BITS, 8, width of the RAM word address.
- DATA_BITS, 32, RAM word width. Must be a multiple of 8. BYTES = DATA_BITS/8.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- i_base_address  input  ADDRESS_BITS  first word address; sampled with i_start.
- i_count  input  ADDRESS_BITS+1  number of words to dump; sampled with i_start; 0 means 2**ADDRESS_BITS.
- o_mem_address  output  ADDRESS_BITS  address driven to the RAM read port.
- i_mem_data  input  DATA_BITS  RAM read data; valid one posedge after the address is driven, because the RAM updates on negedge.
- o_tx_data  output  8  byte to transmit.
- o_tx_start  output  1  one-cycle pulse; the transmitter latches o_tx_data on it.
- i_tx_done  input  1  one-cycle pulse from the transmitter when the byte is finished.
- o_busy  output  1  high from the cycle after an accepted i_start until DONE exits.
- o_done  output  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset values: all outputs 0, state IDLE, word/byte counters 0, shift register 0.
- States: IDLE, FETCH, LOAD, SEND, WAIT_TX, DONE.
- IDLE:
  - When i_start=1, latch i_base_address into the address register and the word count (0 maps to 2**ADDRESS_BITS).
  - o_mem_address = base. Go to FETCH.
- FETCH: one wait cycle; the RAM registers the word on the intervening negedge. Go to LOAD.
- LOAD:
  - Capture i_mem_data into the shift register; byte_idx=0.
  - Go to SEND.
- SEND:
  - o_tx_data = most-significant unsent byte (big-endian: bits DATA_BITS-1..DATA_BITS-8 first).
  - o_tx_start=1 for exactly this cycle. Go to WAIT_TX.
- WAIT_TX:
  - Hold o_tx_data. Wait for i_tx_done, with no timeout.
  - On i_tx_done:
    - If bytes remain in the word: shift left 8, byte_idx++, go to SEND.
    - Else if words remain: address = address+1, wrapping modulo 2**ADDRESS_BITS; words_left--; go to FETCH.
    - Else go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0 next cycle, go to IDLE.
- Latency:
  - i_start to first o_tx_start: 3 cycles (IDLE→FETCH→LOAD→SEND).
  - i_tx_done of a word's last byte to the next word's o_tx_start: 3 cycles.
  - i_tx_done to the next o_tx_start within a word: 1 cycle.
- Boundary conditions:
  - i_start while not IDLE: ignored.
  - i_tx_done outside WAIT_TX, including the same cycle as o_tx_start: ignored.
  - Address wrap: base=2**ADDRESS_BITS-1 with count 2 reads the last address, then address 0.
  - i_count=0: dumps every word once, starting at base.
  - rst asserted in any state, including mid-byte: next cycle is IDLE with outputs at reset values; no o_done. A pending transmitter byte is the transmitter's concern.
  - Simultaneous i_start and rst: rst wins.
  - o_mem_address changes only on entry to FETCH (or in IDLE), so it is stable across the RAM negedge read.

Test Plan:
- Reset, then i_start, base=0x10, count=1, mem[0x10]=0xDEADBEEF, transmitter answers i_tx_done 5 cycles after each o_tx_start:
  - bytes DE, AD, BE, EF in order, four o_tx_start pulses.
  - o_done one cycle after the 4th i_tx_done; o_busy falls after it.
- base=0xFF, count=2, mem[0xFF]=0x11223344, mem[0x00]=0x55667788:
  - o_mem_address sequence FF then 00.
  - Bytes 11 22 33 44 55 66 77 88.
- count=0, memory filled with mem[a]={4{a}}:
  - 1024 bytes, 256 words from base, wrapping through 0.
  - Single o_done at the end.
- Repeated i_start and spurious i_tx_done pulses during SEND/FETCH:
  - Byte stream identical to the scenario 1 run.
  - No extra or skipped bytes.
- rst asserted during WAIT_TX of byte 2 of word 0:
  - Next cycle all outputs 0, state IDLE, no o_done.
  - A following i_start, base=0x10, count=1, restarts cleanly with byte DE.
- Immediate transmitter (i_tx_done the cycle after o_tx_start):
  - o_tx_start spacing is 2 cycles within a word and 4 cycles across words.
